// File: rtl/stall_ram.sv
// stall_ram: single-port word RAM with a programmable grant latency and a
// fixed-latency, in-order response pipeline; counts request stall cycles.
module stall_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned GNT_DELAY  = 1,
  parameter int unsigned RESP_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        port_req_i,
  output logic        port_gnt_o,
  output logic        port_rvalid_o,
  output logic        port_err_o,
  input  logic [31:0] port_addr_i,
  input  logic        port_we_i,
  input  logic [3:0]  port_be_i,
  input  logic [31:0] port_wdata_i,
  output logic [31:0] port_rdata_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned ENTRY_W   = 34;
  localparam int unsigned PIPE_W    = RESP_DELAY * ENTRY_W;
  localparam logic [3:0]  GNT_LIMIT = 4'(GNT_DELAY);

  logic [3:0]            r_wait;
  logic [31:0]           r_stall_cnt;
  logic [31:0]           r_mem [DEPTH];
  logic [PIPE_W-1:0]     r_pipe;

  logic                  w_gnt;
  logic                  w_oor;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_bmask;
  logic                  w_rsp_err;
  logic [31:0]           w_rsp_data;
  logic [ENTRY_W-1:0]    w_entry;
  logic                  w_unused_addr;

  // Reset gates the grant so a zero-delay configuration cannot accept during reset.
  assign w_gnt      = rst_ni & port_req_i & (r_wait == GNT_LIMIT);
  assign port_gnt_o = w_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
    end else if (!port_req_i || w_gnt) begin
      r_wait <= '0;
    end else if (r_wait != GNT_LIMIT) begin
      r_wait <= r_wait + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (port_req_i && !w_gnt) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

  assign w_idx         = port_addr_i[ADDR_WIDTH+1:2];
  assign w_oor         = |port_addr_i[31:ADDR_WIDTH+2];
  assign w_unused_addr = ^port_addr_i[1:0];
  assign w_wr_en       = w_gnt & port_we_i & ~w_oor;
  assign w_rd_word     = r_mem[w_idx];
  assign w_bmask       = {{8{port_be_i[3]}}, {8{port_be_i[2]}},
                          {8{port_be_i[1]}}, {8{port_be_i[0]}}};

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= (w_rd_word & ~w_bmask) | (port_wdata_i & w_bmask);
    end
  end

  assign w_rsp_err  = w_gnt & w_oor;
  assign w_rsp_data = (w_gnt && !w_oor && !port_we_i) ? w_rd_word : '0;
  assign w_entry    = {w_gnt, w_rsp_err, w_rsp_data};

  // Idle slots carry all-zero entries, so err/rdata are zero whenever rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << ENTRY_W) | PIPE_W'(w_entry);
    end
  end

  assign {port_rvalid_o, port_err_o, port_rdata_o} = r_pipe[PIPE_W-1 -: ENTRY_W];

endmodule
